alarm_bank: RTL and testbench
=============================

# alarm_bank

Parametrised multi-channel alarm store and trigger engine for the digital alarm clock. Holds N_ALARMS programmable HHMM alarm times. Each channel:
- retains its time until rewritten or reset;
- arms on load and rings when the minute-aligned current time matches;
- supports snooze and stop, and times out automatically.

Sits between the key/set-data path and the time counter and display/buzzer logic, replacing the single load-while-held alarm register.

## Interface
Parameters:
- N_ALARMS, 4, number of independent alarm channels (1..8)
- TIME_W, 16, alarm/time word width (4 BCD digits HHMM)
- SNOOZE_MIN, 10, snooze length in minute ticks (≥1)
- RING_MAX, 5, minutes a channel rings before auto-stop (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- set_data  in  TIME_W  alarm time to store
- set_sel  in  $clog2(N_ALARMS) (min 1)  target channel for load/disarm
- load_alarm  in  1  1-cycle strobe: write set_data to channel set_sel and arm it
- disarm  in  1  1-cycle strobe: disarm channel set_sel (time retained)
- cur_time  in  TIME_W  current time from the time counter
- min_tick  in  1  1-cycle pulse; cur_time already holds the new minute this cycle
- snooze  in  1  1-cycle strobe: snooze all RINGING channels
- stop  in  1  1-cycle strobe: stop all RINGING/SNOOZED channels
- alarm_data  out  N_ALARMS*TIME_W  stored times; channel i at [i*TIME_W +: TIME_W]
- armed  out  N_ALARMS  channel state ≠ IDLE
- ringing  out  N_ALARMS  channel state = RINGING
- alarm_out  out  1  OR of ringing
- ring_id  out  $clog2(N_ALARMS) (min 1)  lowest-index ringing channel; 0 when none

## Operation
- Per-channel FSM states: IDLE, ARMED, RINGING, SNOOZED.
- Per-channel down-counter, width $clog2(max(SNOOZE_MIN,RING_MAX)+1). It counts snooze minutes in SNOOZED and ring minutes in RINGING.
- Transitions for channel i, evaluated in priority order:
  - load_alarm and set_sel==i: store set_data; go to ARMED; counter cleared. This overrides any ringing or snooze.
  - disarm and set_sel==i: go to IDLE. load_alarm wins if both are asserted.
  - stop, state RINGING or SNOOZED: go to ARMED.
  - snooze, state RINGING: go to SNOOZED; counter = SNOOZE_MIN.
  - min_tick, state ARMED, cur_time == stored time: go to RINGING; counter = RING_MAX.
  - min_tick, state SNOOZED: decrement; on counter==1 go to RINGING with counter = RING_MAX.
  - min_tick, state RINGING: decrement; on counter==1 go to ARMED (timeout).
- Match is on the raw TIME_W compare. No BCD validation.
- A channel returned to ARMED re-triggers at the same time on the next day's match.
- set_sel ≥ N_ALARMS: load_alarm/disarm are ignored.

## Timing
- Reset values:
  - alarm_data = 0, armed = 0, ringing = 0, alarm_out = 0, ring_id = 0
  - all states IDLE, counters 0
- All outputs are registered and change one cycle after the causing strobe or min_tick.
- alarm_data reflects a load on the next cycle. It holds indefinitely; it does not clear when load_alarm drops.
- Snooze of length S: ringing reasserts exactly S min_ticks after the snooze strobe.
- Ring timeout: ringing drops on the RING_MAX-th min_tick after entry.
- snooze and stop in the same cycle: stop wins.
- Strobe coincident with min_tick: the strobe's transition wins. The tick is not re-applied to that channel.
- Reset mid-ring or mid-snooze: everything clears next edge; no pending trigger survives.

## Structure
- Shared package alarm_pkg:
  - state enum (IDLE, ARMED, RINGING, SNOOZED)
  - TIME_W default
  - helper for index width (max of 1 and clog2)
- Sub-module alarm_channel:
  - holds one time word, the FSM and the counter;
  - instantiated N_ALARMS times via generate.
- Top level does:
  - set_sel decode
  - lowest-index priority encoder for ring_id
  - alarm_out OR-reduction

## Test plan
- Reset, then load 16'h0730 to ch1 → alarm_data ch1 = 0730, armed = 0010; hold load low 20 cycles, value retained.
- ch1 armed 0730; min_tick with cur_time 0730 → ringing[1] = 1 and ring_id = 1 next cycle; stop → ringing = 0, armed[1] = 1.
- Ringing ch1, snooze (SNOOZE_MIN=10) → ringing drops; after 9 min_ticks still 0; 10th → ringing[1] = 1.
- ch0 and ch2 both at 0600; tick at 0600 → ringing = 0101, ring_id = 0; one snooze → both SNOOZED.
- Ring untouched for RING_MAX = 5 ticks → ringing drops on the 5th tick, channel ARMED. Disarm ch1 and match its time → no ring.
- Reset asserted while ch3 SNOOZED → all outputs 0 next cycle; a later match on old time does not ring. Simultaneous load_alarm+disarm on ch2 → ch2 ARMED with new data.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm store.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_e;

  localparam int TIME_W_DEF = 16;

  // Index width for a channel selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored HHMM word, IDLE/ARMED/RINGING/SNOOZED FSM and
// a shared snooze/ring minute down-counter.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int TIME_W     = TIME_W_DEF,
  parameter int SNOOZE_MIN = 10,
  parameter int RING_MAX   = 5,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dis,
  input  logic [TIME_W-1:0] set_data,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              min_tick,
  input  logic              snooze,
  input  logic              stop,
  output logic [TIME_W-1:0] time_word,
  output alarm_state_e      state
);

  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  alarm_state_e      state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [TIME_W-1:0] time_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      time_word <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      time_word <= time_next;
    end
  end

  // Strobes are prioritised ahead of min_tick; a strobe that causes a
  // transition consumes the cycle so a coincident tick is not applied.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    time_next  = time_word;
    if (load) begin
      time_next  = set_data;
      state_next = ST_ARMED;
      cnt_next   = '0;
    end else if (dis) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (stop && (state == ST_RINGING || state == ST_SNOOZED)) begin
      state_next = ST_ARMED;
      cnt_next   = '0;
    end else if (snooze && state == ST_RINGING) begin
      state_next = ST_SNOOZED;
      cnt_next   = SNOOZE_LD;
    end else if (min_tick) begin
      case (state)
        ST_ARMED: begin
          if (cur_time == time_word) begin
            state_next = ST_RINGING;
            cnt_next   = RING_LD;
          end
        end
        ST_SNOOZED: begin
          if (cnt == CNT_ONE) begin
            state_next = ST_RINGING;
            cnt_next   = RING_LD;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        ST_RINGING: begin
          if (cnt == CNT_ONE) begin
            state_next = ST_ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm bank: channel select decode, per-channel engines,
// lowest-index ring identification and the combined alarm output.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int TIME_W     = TIME_W_DEF,
  parameter int SNOOZE_MIN = 10,
  parameter int RING_MAX   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [TIME_W-1:0]            set_data,
  input  logic [idx_w(N_ALARMS)-1:0]   set_sel,
  input  logic                         load_alarm,
  input  logic                         disarm,
  input  logic [TIME_W-1:0]            cur_time,
  input  logic                         min_tick,
  input  logic                         snooze,
  input  logic                         stop,
  output logic [N_ALARMS*TIME_W-1:0]   alarm_data,
  output logic [N_ALARMS-1:0]          armed,
  output logic [N_ALARMS-1:0]          ringing,
  output logic                         alarm_out,
  output logic [idx_w(N_ALARMS)-1:0]   ring_id
);

  localparam int SEL_W   = idx_w(N_ALARMS);
  localparam int CNT_MAX = (SNOOZE_MIN > RING_MAX) ? SNOOZE_MIN : RING_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  alarm_state_e ch_state [N_ALARMS];

  // Selectors beyond the last channel match nothing, so those strobes drop.
  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    logic sel_hit;
    assign sel_hit = (set_sel == SEL_W'(i));

    alarm_channel #(
      .TIME_W    (TIME_W),
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_MAX  (RING_MAX),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load_alarm && sel_hit),
      .dis      (disarm && sel_hit),
      .set_data (set_data),
      .cur_time (cur_time),
      .min_tick (min_tick),
      .snooze   (snooze),
      .stop     (stop),
      .time_word(alarm_data[i*TIME_W +: TIME_W]),
      .state    (ch_state[i])
    );

    assign armed[i]   = (ch_state[i] != ST_IDLE);
    assign ringing[i] = (ch_state[i] == ST_RINGING);
  end

  assign alarm_out = |ringing;

  always_comb begin
    ring_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (ringing[i]) ring_id = SEL_W'(i);
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: driver pushes expected outputs, a negedge
// monitor pops and compares against the DUT.
module tb_alarm_bank;

  localparam int N     = 4;
  localparam int TW    = 16;
  localparam int SN    = 10;
  localparam int RM    = 5;
  localparam int SW    = 2;
  localparam int OBS_W = N * TW + N + N + 1 + SW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [TW-1:0]   set_data = '0;
  logic [SW-1:0]   set_sel = '0;
  logic            load_alarm = 1'b0;
  logic            disarm = 1'b0;
  logic [TW-1:0]   cur_time = '0;
  logic            min_tick = 1'b0;
  logic            snooze = 1'b0;
  logic            stop = 1'b0;
  logic [N*TW-1:0] alarm_data;
  logic [N-1:0]    armed;
  logic [N-1:0]    ringing;
  logic            alarm_out;
  logic [SW-1:0]   ring_id;

  alarm_bank #(
    .N_ALARMS  (N),
    .TIME_W    (TW),
    .SNOOZE_MIN(SN),
    .RING_MAX  (RM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_data  (set_data),
    .set_sel   (set_sel),
    .load_alarm(load_alarm),
    .disarm    (disarm),
    .cur_time  (cur_time),
    .min_tick  (min_tick),
    .snooze    (snooze),
    .stop      (stop),
    .alarm_data(alarm_data),
    .armed     (armed),
    .ringing   (ringing),
    .alarm_out (alarm_out),
    .ring_id   (ring_id)
  );

  always #5 clk = ~clk;

  logic [OBS_W-1:0] exp_q[$];
  string            tag_q[$];
  int               n_vec = 0;
  int               n_bad = 0;
  logic [TW-1:0]    e_data [N];

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] m_exp;
  string            m_tag;
  assign obs = {alarm_data, armed, ringing, alarm_out, ring_id};

  function automatic logic [SW-1:0] low_id(input logic [N-1:0] r);
    logic [SW-1:0] id;
    id = '0;
    for (int i = N - 1; i >= 0; i--) if (r[i]) id = SW'(i);
    return id;
  endfunction

  task automatic expect_out(input string tag, input logic [N-1:0] e_arm,
                            input logic [N-1:0] e_ring);
    exp_q.push_back({e_data[3], e_data[2], e_data[1], e_data[0],
                     e_arm, e_ring, |e_ring, low_id(e_ring)});
    tag_q.push_back(tag);
  endtask

  // Outputs are stable between the +1 drive point and the next rising edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      n_vec++;
      if (obs !== m_exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", m_tag, obs, m_exp);
      end
    end
  end

  task automatic tick_edge();
    @(posedge clk);
    #1;
    load_alarm = 1'b0;
    disarm     = 1'b0;
    min_tick   = 1'b0;
    snooze     = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic do_load(input int sel, input logic [TW-1:0] d);
    set_sel    = SW'(sel);
    set_data   = d;
    load_alarm = 1'b1;
    tick_edge();
  endtask

  task automatic do_disarm(input int sel);
    set_sel = SW'(sel);
    disarm  = 1'b1;
    tick_edge();
  endtask

  task automatic do_tick(input logic [TW-1:0] t);
    cur_time = t;
    min_tick = 1'b1;
    tick_edge();
  endtask

  task automatic do_snooze();
    snooze = 1'b1;
    tick_edge();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick_edge();
  endtask

  initial begin
    for (int i = 0; i < N; i++) e_data[i] = '0;
    tick_edge();
    tick_edge();
    reset = 1'b0;
    expect_out("reset", 4'b0000, 4'b0000);

    do_load(1, 16'h0730);
    e_data[1] = 16'h0730;
    expect_out("load_ch1", 4'b0010, 4'b0000);
    repeat (20) tick_edge();
    expect_out("hold_ch1", 4'b0010, 4'b0000);

    do_tick(16'h0729);
    expect_out("no_match", 4'b0010, 4'b0000);
    do_tick(16'h0730);
    expect_out("ring_ch1", 4'b0010, 4'b0010);
    do_stop();
    expect_out("stop_ch1", 4'b0010, 4'b0000);

    do_tick(16'h0730);
    expect_out("retrigger", 4'b0010, 4'b0010);
    do_snooze();
    expect_out("snooze_ch1", 4'b0010, 4'b0000);
    for (int k = 1; k <= 9; k++) begin
      do_tick(16'h0800 + TW'(k));
      expect_out("snooze_wait", 4'b0010, 4'b0000);
    end
    do_tick(16'h0810);
    expect_out("snooze_end", 4'b0010, 4'b0010);
    do_stop();
    expect_out("stop_again", 4'b0010, 4'b0000);

    do_load(0, 16'h0600);
    e_data[0] = 16'h0600;
    do_load(2, 16'h0600);
    e_data[2] = 16'h0600;
    expect_out("load_ch0_ch2", 4'b0111, 4'b0000);
    do_tick(16'h0600);
    expect_out("ring_two", 4'b0111, 4'b0101);
    do_snooze();
    expect_out("snooze_two", 4'b0111, 4'b0000);
    for (int k = 1; k <= 9; k++) begin
      do_tick(16'h0900 + TW'(k));
    end
    expect_out("snooze_two_9", 4'b0111, 4'b0000);
    do_tick(16'h0910);
    expect_out("snooze_two_10", 4'b0111, 4'b0101);

    for (int k = 1; k <= 4; k++) begin
      do_tick(16'h0920 + TW'(k));
      expect_out("ring_hold", 4'b0111, 4'b0101);
    end
    do_tick(16'h0925);
    expect_out("ring_timeout", 4'b0111, 4'b0000);

    do_disarm(1);
    expect_out("disarm_ch1", 4'b0101, 4'b0000);
    do_tick(16'h0730);
    expect_out("disarmed_match", 4'b0101, 4'b0000);

    // snooze+stop together must leave the channels ARMED, not SNOOZED
    do_tick(16'h0600);
    expect_out("ring_again", 4'b0101, 4'b0101);
    snooze = 1'b1;
    stop   = 1'b1;
    tick_edge();
    expect_out("stop_over_snooze", 4'b0101, 4'b0000);
    for (int k = 1; k <= 10; k++) do_tick(16'h1000 + TW'(k));
    expect_out("no_snooze_ring", 4'b0101, 4'b0000);

    // load coincident with a matching tick arms without ringing
    set_sel    = 2'd3;
    set_data   = 16'h0800;
    load_alarm = 1'b1;
    cur_time   = 16'h0800;
    min_tick   = 1'b1;
    tick_edge();
    e_data[3] = 16'h0800;
    expect_out("load_wins_tick", 4'b1101, 4'b0000);
    do_tick(16'h0800);
    expect_out("ring_ch3", 4'b1101, 4'b1000);
    do_snooze();
    do_tick(16'h0801);
    do_tick(16'h0802);
    expect_out("ch3_snoozed", 4'b1101, 4'b0000);

    reset = 1'b1;
    tick_edge();
    reset = 1'b0;
    for (int i = 0; i < N; i++) e_data[i] = '0;
    expect_out("reset_mid_snooze", 4'b0000, 4'b0000);
    for (int k = 1; k <= 10; k++) do_tick(16'h0802 + TW'(k));
    do_tick(16'h0800);
    expect_out("no_ring_after_reset", 4'b0000, 4'b0000);

    do_load(2, 16'h0600);
    e_data[2] = 16'h0600;
    set_sel    = 2'd2;
    set_data   = 16'h1234;
    load_alarm = 1'b1;
    disarm     = 1'b1;
    tick_edge();
    e_data[2] = 16'h1234;
    expect_out("load_over_disarm", 4'b0100, 4'b0000);
    do_tick(16'h1234);
    expect_out("ring_ch2", 4'b0100, 4'b0100);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
